// File: rtl/data_chk_interleaver_if.sv
// Stream bundle for the data/checksum interleaver: two input streams and the merged output.
// The DUT uses the slave view; the producer/consumer side uses the master view.
interface data_chk_interleaver_if #(
    parameter int DATA_W = 512,
    parameter int ID_W   = 6
);
    localparam int KEEP_W = DATA_W / 8;

    logic [DATA_W-1:0] inp_data;
    logic [KEEP_W-1:0] inp_keep;
    logic [ID_W-1:0]   inp_id;
    logic              inp_last;
    logic              inp_valid;
    logic              inp_ready;

    logic [DATA_W-1:0] chk_data;
    logic [KEEP_W-1:0] chk_keep;
    logic [ID_W-1:0]   chk_id;
    logic              chk_last;
    logic              chk_valid;
    logic              chk_ready;

    logic [DATA_W-1:0] out;
    logic [KEEP_W-1:0] out_keep;
    logic [ID_W-1:0]   out_id;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output inp_data, inp_keep, inp_id, inp_last, inp_valid,
        input  inp_ready,
        output chk_data, chk_keep, chk_id, chk_last, chk_valid,
        input  chk_ready,
        input  out, out_keep, out_id, out_last, out_valid,
        output out_ready
    );

    modport slave (
        input  inp_data, inp_keep, inp_id, inp_last, inp_valid,
        output inp_ready,
        input  chk_data, chk_keep, chk_id, chk_last, chk_valid,
        output chk_ready,
        output out, out_keep, out_id, out_last, out_valid,
        input  out_ready
    );
endinterface

// File: rtl/data_chk_interleaver.sv
// Merges a data stream and a checksum stream: up to CHUNK_BEATS data beats (or fewer when
// closed by inp_last) followed by exactly one checksum beat, through one output register.
module data_chk_interleaver #(
    parameter int DATA_W      = 512,
    parameter int ID_W        = 6,
    parameter int CHUNK_BEATS = 4,
    parameter int LAST_MODE   = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    data_chk_interleaver_if.slave   bus,
    output logic [31:0]             chunk_cnt,
    output logic                    id_err
);
    localparam int CNT_W = $clog2(CHUNK_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(CHUNK_BEATS - 1);

    typedef enum logic {DATA, CHK} state_t;

    state_t            state, state_next;
    logic              load_en;
    logic              inp_fire;
    logic              chk_fire;
    logic              close_chunk;
    logic [CNT_W-1:0]  beat_cnt;
    logic              closed_by_last;
    logic [ID_W-1:0]   chunk_id;

    assign load_en     = !bus.out_valid || bus.out_ready;
    assign close_chunk = bus.inp_last || (beat_cnt == LAST_BEAT);
    assign inp_fire    = bus.inp_valid && bus.inp_ready;
    assign chk_fire    = bus.chk_valid && bus.chk_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= DATA;
        else       state <= state_next;
    end

    // Readies are gated by reset so both read low while it is held.
    always_comb begin
        state_next    = state;
        bus.inp_ready = 1'b0;
        bus.chk_ready = 1'b0;
        if (!reset) begin
            case (state)
                DATA: begin
                    bus.inp_ready = load_en;
                    if (bus.inp_valid && load_en && close_chunk) state_next = CHK;
                end
                CHK: begin
                    bus.chk_ready = load_en;
                    if (bus.chk_valid && load_en) state_next = DATA;
                end
                default: state_next = DATA;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            beat_cnt       <= '0;
            closed_by_last <= 1'b0;
            chunk_id       <= '0;
            chunk_cnt      <= '0;
            id_err         <= 1'b0;
            bus.out        <= '0;
            bus.out_keep   <= '0;
            bus.out_id     <= '0;
            bus.out_last   <= 1'b0;
            bus.out_valid  <= 1'b0;
        end else begin
            if (inp_fire) begin
                if (beat_cnt == '0) chunk_id <= bus.inp_id;
                if (close_chunk) begin
                    beat_cnt       <= '0;
                    closed_by_last <= bus.inp_last;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end

            if (chk_fire) begin
                chunk_cnt <= chunk_cnt + 32'd1;
                if (bus.chk_id != chunk_id) id_err <= 1'b1;
            end

            if (inp_fire) begin
                bus.out       <= bus.inp_data;
                bus.out_keep  <= bus.inp_keep;
                bus.out_id    <= bus.inp_id;
                bus.out_last  <= 1'b0;
                bus.out_valid <= 1'b1;
            end else if (chk_fire) begin
                bus.out       <= bus.chk_data;
                bus.out_keep  <= bus.chk_keep;
                bus.out_id    <= bus.chk_id;
                bus.out_last  <= (LAST_MODE == 1) ? closed_by_last : bus.chk_last;
                bus.out_valid <= 1'b1;
            end else if (load_en) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule
